gate_checker: RTL and testbench

GATE_CHECKER -- requirements
Module: gate_checker

---
 rtl/gate_checker.sv | 145 ++++++++++++++
 tb/tb_gate_checker.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/gate_checker.sv
// Checks a two-input gate by sweeping all four input vectors and comparing its output
// against the selected ideal function. It records the mismatch count and the first failing vector.
module gate_checker #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] gate_sel,
  input  logic       dut_c,
  output logic       dut_a,
  output logic       dut_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic       fail_valid,
  output logic [1:0] fail_vec
);

  typedef enum logic [1:0] {StIdle, StWait, StCheck} state_e;

  localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic       fvalid_q, fvalid_d;
  logic [1:0] fvec_q, fvec_d;
  logic       mismatch;

  function automatic logic expected(input logic [2:0] sel, input logic a, input logic b);
    logic r;
    case (sel)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = ~(a & b);
      3'd3:    r = ~(a | b);
      3'd4:    r = a ^ b;
      3'd5:    r = ~(a ^ b);
      3'd6:    r = a;
      default: r = ~a;
    endcase
    return r;
  endfunction

  // The vector index doubles as the drive value, so the last vector stays on the pins in idle.
  assign dut_a      = vec_q[1];
  assign dut_b      = vec_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign fail_valid = fvalid_q;
  assign fail_vec   = fvec_q;

  assign mismatch = (dut_c != expected(sel_q, vec_q[1], vec_q[0]));

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    fvalid_d = fvalid_q;
    fvec_d   = fvec_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          sel_d    = gate_sel;
          vec_d    = 2'b00;
          cnt_d    = 4'd0;
          err_d    = 3'd0;
          pass_d   = 1'b0;
          fvalid_d = 1'b0;
          fvec_d   = 2'b00;
          busy_d   = 1'b1;
          state_d  = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SettleLast) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (mismatch) begin
          err_d = err_q + 3'd1;
          if (!fvalid_q) begin
            fvalid_d = 1'b1;
            fvec_d   = vec_q;
          end
        end
        if (vec_q != 2'b11) begin
          vec_d   = vec_q + 2'd1;
          cnt_d   = 4'd0;
          state_d = StWait;
        end else begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 3'd0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      sel_q    <= 3'd0;
      vec_q    <= 2'b00;
      cnt_q    <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= 3'd0;
      fvalid_q <= 1'b0;
      fvec_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fvalid_q <= fvalid_d;
      fvec_q   <= fvec_d;
    end
  end

endmodule

// File: tb/tb_gate_checker.sv
// Randomized bench for gate_checker: a truth-table gate model drives dut_c, and each run's
// expected results and latency come from a table-driven reference model.
module tb_gate_checker;

  localparam int unsigned SETTLE = 2;
  localparam int LATENCY = 4 * (SETTLE + 1);

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] gate_sel;
  logic       dut_c;
  logic       dut_a;
  logic       dut_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_cnt;
  logic       fail_valid;
  logic [1:0] fail_vec;

  // Behaviour of the gate under test, indexed by {a,b}.
  logic [3:0] model_tt;

  int n_checks = 0;
  int n_errors = 0;

  gate_checker #(.SETTLE(SETTLE)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .gate_sel   (gate_sel),
    .dut_c      (dut_c),
    .dut_a      (dut_a),
    .dut_b      (dut_b),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_cnt    (err_cnt),
    .fail_valid (fail_valid),
    .fail_vec   (fail_vec)
  );

  always #5 clk = ~clk;

  assign dut_c = model_tt[{dut_a, dut_b}];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ideal_tt(input logic [2:0] sel);
    case (sel)
      3'd0:    return 4'b1000;
      3'd1:    return 4'b1110;
      3'd2:    return 4'b0111;
      3'd3:    return 4'b0001;
      3'd4:    return 4'b0110;
      3'd5:    return 4'b1001;
      3'd6:    return 4'b1100;
      default: return 4'b0011;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ab"}, {dut_a, dut_b}, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"}, err_cnt, 0);
    check({tag, "_fvalid"}, fail_valid, 0);
    check({tag, "_fvec"}, fail_vec, 0);
  endtask

  // Starts at a negedge with the checker idle; ends at the negedge where done is seen
  // (or one cycle later when start is not held).
  task automatic do_run(input logic [2:0] sel, input logic [3:0] mtt, input bit disturb,
                        input bit hold_start);
    logic [3:0] exp_tt;
    int         errs;
    int         first;
    int         cycles;
    exp_tt = ideal_tt(sel);
    errs   = 0;
    first  = 0;
    for (int v = 0; v < 4; v++) begin
      if (mtt[v] != exp_tt[v]) begin
        if (errs == 0) first = v;
        errs++;
      end
    end

    gate_sel = sel;
    model_tt = mtt;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("accept_busy", busy, 1);
    check("accept_err_clr", err_cnt, 0);
    check("accept_done_low", done, 0);
    start  = hold_start;
    cycles = 0;
    while (!done && cycles < 40) begin
      gate_sel = 3'($urandom);
      if (disturb) start = hold_start | (cycles == 3) | (cycles == 7);
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (!done) check("run_busy", busy, 1);
    end
    start = hold_start;
    check("latency", cycles, LATENCY);
    check("done_busy_low", busy, 0);
    check("pass", pass, (errs == 0) ? 1 : 0);
    check("err_cnt", err_cnt, errs);
    check("fail_valid", fail_valid, (errs != 0) ? 1 : 0);
    check("fail_vec", fail_vec, first);
    if (!hold_start) begin
      @(posedge clk);
      @(negedge clk);
      check("done_width", done, 0);
      check("idle_ab", {dut_a, dut_b}, 3);
      check("hold_err_cnt", err_cnt, errs);
      check("hold_pass", pass, (errs == 0) ? 1 : 0);
    end
  endtask

  initial begin
    int seen;
    rst      = 1'b1;
    start    = 1'b1;
    gate_sel = 3'd0;
    model_tt = 4'b1000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);

    do_run(3'd0, 4'b1000, 1'b0, 1'b0);
    do_run(3'd0, 4'b0000, 1'b0, 1'b0);
    do_run(3'd4, 4'b1000, 1'b0, 1'b0);
    for (int s = 0; s < 8; s++) do_run(3'(s), ideal_tt(3'(s)), 1'b0, 1'b0);
    do_run(3'd1, 4'b1000, 1'b1, 1'b0);

    // Reset during the wait phase of vector 2.
    gate_sel = 3'd4;
    model_tt = 4'b1000;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("midrun_rst");
    seen = 0;
    repeat (15) begin
      @(posedge clk);
      @(negedge clk);
      if (done) seen++;
    end
    check("no_done_after_rst", seen, 0);
    do_run(3'd2, 4'b0111, 1'b0, 1'b0);

    // Back-to-back runs with start held high.
    do_run(3'd0, 4'b1111, 1'b0, 1'b1);
    do_run(3'd0, 4'b1111, 1'b0, 1'b1);
    do_run(3'd5, 4'b1001, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      logic [2:0] s;
      logic [3:0] m;
      s = 3'($urandom);
      m = ($urandom_range(0, 1) == 0) ? ideal_tt(s) : 4'($urandom);
      do_run(s, m, 1'($urandom), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
